// File: rtl/axil_pkg.sv
// axil_pkg: state encoding and AXI4-lite constants shared by the native-to-AXI4-lite bridge.
package axil_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_DONE
    } axim_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [2:0] AXI_PROT_INSN   = 3'b100;

endpackage

// File: rtl/axim_watchdog.sv
// axim_watchdog: counts waiting cycles in one handshake phase and flags when the limit is hit.
module axim_watchdog #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt_d     = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/axil_mem_initiator.sv
// axil_mem_initiator: picorv32-style native memory port to AXI4-lite initiator, one access at a time.
// Define AXIM_TIMEOUT_EN to abort any handshake phase stalled for TIMEOUT_CYCLES with mem_err.
module axil_mem_initiator
    import axil_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_valid,
    input  logic                mem_instr,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_ready,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_err,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    input  logic [1:0]          m_axi_bresp,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp
);
    axim_state_e         state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                instr_q, instr_d, err_q, err_d;
    logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                timeout;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        instr_d   = instr_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            S_IDLE: if (mem_valid) begin
                addr_d    = mem_addr;
                wdata_d   = mem_wdata;
                wstrb_d   = mem_wstrb;
                instr_d   = mem_instr;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = |mem_wstrb ? S_WR_ADDR_DATA : S_RD_ADDR;
            end
            S_RD_ADDR: if (m_axi_arready) state_d = S_RD_DATA;
            S_RD_DATA: if (m_axi_rvalid) begin
                rdata_d = m_axi_rdata;
                err_d   = m_axi_rresp != AXI_RESP_OKAY;
                state_d = S_DONE;
            end
            // AW and W retire independently; a channel's valid drops once its done flag is set
            S_WR_ADDR_DATA: begin
                aw_done_d = aw_done_q | m_axi_awready;
                w_done_d  = w_done_q | m_axi_wready;
                if (aw_done_d && w_done_d) state_d = S_WR_RESP;
            end
            S_WR_RESP: if (m_axi_bvalid) begin
                err_d   = m_axi_bresp != AXI_RESP_OKAY;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // A handshake landing on the expiry cycle wins over the abort
        if (timeout && state_d == state_q) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            instr_q   <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            instr_q   <= instr_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

`ifdef AXIM_TIMEOUT_EN
    logic waiting;

    assign waiting = state_q inside {S_RD_ADDR, S_RD_DATA, S_WR_ADDR_DATA, S_WR_RESP};

    axim_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_d != state_q),
        .en_i      (waiting),
        .expired_o (timeout)
    );
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = TIMEOUT_CYCLES != 0;
`endif

    assign m_axi_arvalid = state_q == S_RD_ADDR;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = instr_q ? AXI_PROT_INSN : 3'b000;
    assign m_axi_rready  = state_q == S_RD_DATA;
    assign m_axi_awvalid = state_q == S_WR_ADDR_DATA && !aw_done_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = state_q == S_WR_ADDR_DATA && !w_done_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_bready  = state_q == S_WR_RESP;
    assign mem_ready     = state_q == S_DONE;
    assign mem_err       = mem_ready && err_q;
    assign mem_rdata     = rdata_q;

endmodule
